// File: rtl/pong_pixel_gen_if.sv
// Video timing, button and VGA pin bundle shared by the timing controller side
// (master) and the Pong pixel generator (slave).
interface pong_pixel_gen_if;
  logic        CE;
  logic        VIDEO_ON;
  logic        HSYNC_IN;
  logic        VSYNC_IN;
  logic [9:0]  X;
  logic [9:0]  Y;
  logic        BTN_UP_L;
  logic        BTN_DN_L;
  logic        BTN_UP_R;
  logic        BTN_DN_R;
  logic [11:0] RGB;
  logic        HSYNC;
  logic        VSYNC;
  logic [3:0]  SCORE_L;
  logic [3:0]  SCORE_R;
  logic        GAME_OVER;

  modport master (
    output CE, VIDEO_ON, HSYNC_IN, VSYNC_IN, X, Y,
    output BTN_UP_L, BTN_DN_L, BTN_UP_R, BTN_DN_R,
    input  RGB, HSYNC, VSYNC, SCORE_L, SCORE_R, GAME_OVER
  );

  modport slave (
    input  CE, VIDEO_ON, HSYNC_IN, VSYNC_IN, X, Y,
    input  BTN_UP_L, BTN_DN_L, BTN_UP_R, BTN_DN_R,
    output RGB, HSYNC, VSYNC, SCORE_L, SCORE_R, GAME_OVER
  );
endinterface

// File: rtl/pong_pixel_gen.sv
// Pong game state (paddles, ball, scores) updated once per frame, plus the
// registered RGB pixel and one-pixel re-timed syncs that drive the VGA pins.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_SERVE | ball parked at centre, serve counter runs for SERVE_FRAMES
// ST_PLAY  | ball moves, bounces off walls/paddles, misses score a point
// ST_OVER  | a player reached WIN_SCORE; ball hidden, paddles frozen
module pong_pixel_gen #(
  parameter int PADDLE_H     = 80,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int PAD_L_X      = 32,
  parameter int PAD_R_X      = 600,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic             CLK,
  input  logic             RESET,
  pong_pixel_gen_if.slave  vga
);

  typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_OVER} state_t;

  localparam int SRV_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [9:0]       PTOP_MAX = 10'(480 - PADDLE_H);
  localparam logic [9:0]       PTOP_RST = 10'((480 - PADDLE_H) / 2);
  localparam logic [9:0]       PS10     = 10'(PADDLE_SPEED);
  localparam logic [9:0]       BALL_X0  = 10'd316;
  localparam logic [9:0]       BALL_Y0  = 10'd236;
  localparam logic [10:0]      BS       = 11'(BALL_SPEED);
  localparam logic [10:0]      X_MAX    = 11'd632;
  localparam logic [10:0]      Y_MAX    = 11'd472;
  localparam logic [10:0]      PLX      = 11'(PAD_L_X);
  localparam logic [10:0]      PRX      = 11'(PAD_R_X);
  localparam logic [10:0]      PH       = 11'(PADDLE_H);
  localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_FRAMES - 1);
  localparam logic [3:0]       WIN4     = 4'(WIN_SCORE);

  state_t            state_q, state_d;
  logic [SRV_W-1:0]  srv_cnt_q, srv_cnt_d;
  logic [9:0]        pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  logic [9:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic              vx_q, vx_d, vy_q, vy_d;       // 1 = positive direction
  logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;

  logic              tick;
  logic [10:0]       bx, by, pl, pr, xx, yy;
  logic              ball_px, pad_px, net_px;

  // Frame tick lands on the first blanked line, so rendering never sees a half-updated frame.
  assign tick = vga.CE && (vga.X == 10'd0) && (vga.Y == 10'd480);

  assign bx = {1'b0, ball_x_q};
  assign by = {1'b0, ball_y_q};
  assign pl = {1'b0, pad_l_q};
  assign pr = {1'b0, pad_r_q};
  assign xx = {1'b0, vga.X};
  assign yy = {1'b0, vga.Y};

  function automatic logic [9:0] pad_step(input logic [9:0] top, input logic up, input logic dn);
    logic [9:0] r;
    r = top;
    if (up && !dn)      r = (top < PS10) ? 10'd0 : top - PS10;
    else if (dn && !up) r = (top > PTOP_MAX - PS10) ? PTOP_MAX : top + PS10;
    return r;
  endfunction

  // Per-frame game update: paddles, serve sequencing, ball motion and scoring.
  always_comb begin
    state_d   = state_q;
    srv_cnt_d = srv_cnt_q;
    pad_l_d   = pad_l_q;
    pad_r_d   = pad_r_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if (tick) begin
      if (state_q != ST_OVER) begin
        pad_l_d = pad_step(pad_l_q, vga.BTN_UP_L, vga.BTN_DN_L);
        pad_r_d = pad_step(pad_r_q, vga.BTN_UP_R, vga.BTN_DN_R);
      end
      case (state_q)
        ST_SERVE: begin
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
          if (srv_cnt_q == SRV_LAST) begin
            srv_cnt_d = '0;
            state_d   = ST_PLAY;
          end else begin
            srv_cnt_d = srv_cnt_q + 1'b1;
          end
        end
        ST_PLAY: begin
          if (!vy_q && by < BS) begin
            ball_y_d = 10'd0;
            vy_d     = 1'b1;
          end else if (vy_q && (by + BS) > Y_MAX) begin
            ball_y_d = Y_MAX[9:0];
            vy_d     = 1'b0;
          end else if (vy_q) begin
            ball_y_d = 10'(by + BS);
          end else begin
            ball_y_d = 10'(by - BS);
          end

          // A miss overrides any wall bounce position: the ball re-centres for the serve.
          if (!vx_q && bx < BS) begin
            score_r_d = score_r_q + 4'd1;
            state_d   = (score_r_d == WIN4) ? ST_OVER : ST_SERVE;
            vx_d      = 1'b1;
            ball_x_d  = BALL_X0;
            ball_y_d  = BALL_Y0;
          end else if (vx_q && (bx + BS) > X_MAX) begin
            score_l_d = score_l_q + 4'd1;
            state_d   = (score_l_d == WIN4) ? ST_OVER : ST_SERVE;
            vx_d      = 1'b0;
            ball_x_d  = BALL_X0;
            ball_y_d  = BALL_Y0;
          end else if (!vx_q && bx <= PLX + 11'd8 + BS && bx >= PLX &&
                       (by + 11'd8) > pl && by < (pl + PH)) begin
            ball_x_d = 10'(PLX + 11'd8);
            vx_d     = 1'b1;
          end else if (vx_q && (bx + 11'd8 + BS) >= PRX && bx <= PRX &&
                       (by + 11'd8) > pr && by < (pr + PH)) begin
            ball_x_d = 10'(PRX - 11'd8);
            vx_d     = 1'b0;
          end else if (vx_q) begin
            ball_x_d = 10'(bx + BS);
          end else begin
            ball_x_d = 10'(bx - BS);
          end
        end
        default: ;
      endcase
    end
  end

  assign ball_px = (state_q != ST_OVER) &&
                   (xx >= bx) && (xx < bx + 11'd8) && (yy >= by) && (yy < by + 11'd8);
  assign pad_px  = ((xx >= PLX) && (xx < PLX + 11'd8) && (yy >= pl) && (yy < pl + PH)) ||
                   ((xx >= PRX) && (xx < PRX + 11'd8) && (yy >= pr) && (yy < pr + PH));
  assign net_px  = (xx >= 11'd318) && (xx <= 11'd321) && !vga.Y[3];

  // Pixel colour and sync re-timing, one pixel behind the incoming coordinates.
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (vga.CE) begin
      hsync_d = vga.HSYNC_IN;
      vsync_d = vga.VSYNC_IN;
      if (!vga.VIDEO_ON) rgb_d = 12'h000;
      else if (ball_px)  rgb_d = 12'hFFF;
      else if (pad_px)   rgb_d = 12'h0F0;
      else if (net_px)   rgb_d = 12'h888;
      else               rgb_d = 12'h000;
    end
  end

  // State registers advance on pixel-strobe cycles; reset wins on any edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_SERVE;
      srv_cnt_q <= '0;
      pad_l_q   <= PTOP_RST;
      pad_r_q   <= PTOP_RST;
      ball_x_q  <= BALL_X0;
      ball_y_q  <= BALL_Y0;
      vx_q      <= 1'b1;
      vy_q      <= 1'b1;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      rgb_q     <= 12'h000;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
    end else if (vga.CE) begin
      state_q   <= state_d;
      srv_cnt_q <= srv_cnt_d;
      pad_l_q   <= pad_l_d;
      pad_r_q   <= pad_r_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      rgb_q     <= rgb_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign vga.RGB       = rgb_q;
  assign vga.HSYNC     = hsync_q;
  assign vga.VSYNC     = vsync_q;
  assign vga.SCORE_L   = score_l_q;
  assign vga.SCORE_R   = score_r_q;
  assign vga.GAME_OVER = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_pixel_gen.sv
// Directed bench for pong_pixel_gen: frame ticks are injected directly as
// (X=0,Y=480,CE=1) and game state is observed by probing single pixels.
module tb_pong_pixel_gen;
  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp = 0;
  int   n_err = 0;

  always #10 CLK = ~CLK;

  pong_pixel_gen_if bus ();
  pong_pixel_gen dut (.CLK(CLK), .RESET(RESET), .vga(bus));

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    bus.CE = 1'b0;
    repeat (3) cyc();
    RESET = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.X = 10'd0; bus.Y = 10'd480; bus.VIDEO_ON = 1'b0; bus.CE = 1'b1;
      cyc();
      bus.CE = 1'b0;
      cyc();
    end
  endtask

  task automatic probe(input int px, input int py, input logic von, output logic [11:0] c);
    bus.X = 10'(px); bus.Y = 10'(py); bus.VIDEO_ON = von; bus.CE = 1'b1;
    cyc();
    c = bus.RGB;
    bus.CE = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] c;
    RESET = 1'b1; bus.CE = 1'b1; bus.HSYNC_IN = 1'b1; bus.VSYNC_IN = 1'b1;
    bus.VIDEO_ON = 1'b1; bus.X = 10'd316; bus.Y = 10'd236;
    repeat (3) cyc();
    n_cmp++; if (bus.RGB !== 12'h000) begin n_err++; $display("FAIL rst_rgb got %h want 000", bus.RGB); end
    n_cmp++; if (bus.HSYNC !== 1'b0) begin n_err++; $display("FAIL rst_hsync got %b want 0", bus.HSYNC); end
    n_cmp++; if (bus.VSYNC !== 1'b0) begin n_err++; $display("FAIL rst_vsync got %b want 0", bus.VSYNC); end
    n_cmp++; if (bus.SCORE_L !== 4'd0 || bus.SCORE_R !== 4'd0) begin n_err++; $display("FAIL rst_score got %0d/%0d want 0/0", bus.SCORE_L, bus.SCORE_R); end
    n_cmp++; if (bus.GAME_OVER !== 1'b0) begin n_err++; $display("FAIL rst_go got %b want 0", bus.GAME_OVER); end
    RESET = 1'b0; bus.CE = 1'b0; bus.HSYNC_IN = 1'b0; bus.VSYNC_IN = 1'b0;
    tick_n(2);
    probe(320, 0, 1'b1, c);   n_cmp++; if (c !== 12'h888) begin n_err++; $display("FAIL net_320_0 got %h want 888", c); end
    probe(320, 8, 1'b1, c);   n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL net_gap_320_8 got %h want 000", c); end
    probe(32, 200, 1'b1, c);  n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL padl_top got %h want 0F0", c); end
    probe(32, 199, 1'b1, c);  n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL padl_above got %h want 000", c); end
    probe(600, 279, 1'b1, c); n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL padr_bottom got %h want 0F0", c); end
    probe(600, 280, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL padr_below got %h want 000", c); end
    probe(316, 236, 1'b1, c); n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL ball_serve got %h want FFF", c); end
    probe(324, 236, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL ball_right_edge got %h want 000", c); end
    probe(316, 236, 1'b0, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL blank_ball got %h want 000", c); end
    n_cmp++; if (bus.SCORE_L !== 4'd0 || bus.SCORE_R !== 4'd0) begin n_err++; $display("FAIL idle_score got %0d/%0d want 0/0", bus.SCORE_L, bus.SCORE_R); end
  endtask

  task automatic test_mid_reset();
    bus.HSYNC_IN = 1'b1; bus.CE = 1'b1;
    cyc();
    n_cmp++; if (bus.HSYNC !== 1'b1) begin n_err++; $display("FAIL mr_hs_pre got %b want 1", bus.HSYNC); end
    bus.CE = 1'b0; RESET = 1'b1;
    cyc();
    n_cmp++; if (bus.HSYNC !== 1'b0) begin n_err++; $display("FAIL mr_hs_rst got %b want 0", bus.HSYNC); end
    RESET = 1'b0;
    cyc();
    n_cmp++; if (bus.HSYNC !== 1'b0) begin n_err++; $display("FAIL mr_hs_hold got %b want 0", bus.HSYNC); end
    bus.CE = 1'b1;
    cyc();
    n_cmp++; if (bus.HSYNC !== 1'b1) begin n_err++; $display("FAIL mr_hs_ce got %b want 1", bus.HSYNC); end
    bus.CE = 1'b0; bus.HSYNC_IN = 1'b0;
  endtask

  task automatic test_paddle();
    logic [11:0] c;
    do_reset();
    bus.BTN_UP_L = 1'b1;
    tick_n(1);
    probe(32, 196, 1'b1, c); n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL up1_top got %h want 0F0", c); end
    probe(32, 195, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL up1_above got %h want 000", c); end
    tick_n(59);
    probe(32, 0, 1'b1, c);   n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL upsat_top got %h want 0F0", c); end
    probe(32, 79, 1'b1, c);  n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL upsat_bot got %h want 0F0", c); end
    probe(32, 80, 1'b1, c);  n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL upsat_below got %h want 000", c); end
    bus.BTN_DN_L = 1'b1;
    tick_n(5);
    probe(32, 0, 1'b1, c);   n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL both_top got %h want 0F0", c); end
    probe(32, 80, 1'b1, c);  n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL both_below got %h want 000", c); end
    bus.BTN_UP_L = 1'b0;
    tick_n(1);
    probe(32, 3, 1'b1, c);   n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL dn1_above got %h want 000", c); end
    probe(32, 4, 1'b1, c);   n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL dn1_top got %h want 0F0", c); end
    tick_n(110);
    probe(32, 399, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL dnsat_above got %h want 000", c); end
    probe(32, 400, 1'b1, c); n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL dnsat_top got %h want 0F0", c); end
    probe(32, 479, 1'b1, c); n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL dnsat_bot got %h want 0F0", c); end
    probe(600, 199, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL padr_still_above got %h want 000", c); end
    probe(600, 200, 1'b1, c); n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL padr_still_top got %h want 0F0", c); end
    bus.BTN_DN_L = 1'b0;
  endtask

  task automatic test_serve_motion();
    logic [11:0] c;
    do_reset();
    tick_n(60);
    probe(316, 236, 1'b1, c); n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL serve_end got %h want FFF", c); end
    tick_n(1);
    probe(316, 236, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL play1_old got %h want 000", c); end
    probe(318, 238, 1'b1, c); n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL play1_new got %h want FFF", c); end
    bus.X = 10'd0; bus.Y = 10'd480; bus.VIDEO_ON = 1'b0; bus.CE = 1'b0;
    repeat (5) cyc();
    tick_n(9);
    probe(336, 256, 1'b1, c); n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL play10_tl got %h want FFF", c); end
    probe(335, 256, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL play10_left got %h want 000", c); end
    probe(336, 255, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL play10_up got %h want 000", c); end
    probe(343, 263, 1'b1, c); n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL play10_br got %h want FFF", c); end
    probe(344, 263, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL play10_right got %h want 000", c); end
    bus.HSYNC_IN = 1'b1; bus.CE = 1'b0;
    cyc();
    n_cmp++; if (bus.HSYNC !== 1'b0) begin n_err++; $display("FAIL hs_noce got %b want 0", bus.HSYNC); end
    bus.CE = 1'b1;
    cyc();
    n_cmp++; if (bus.HSYNC !== 1'b1) begin n_err++; $display("FAIL hs_ce got %b want 1", bus.HSYNC); end
    bus.HSYNC_IN = 1'b0; bus.VSYNC_IN = 1'b1;
    cyc();
    n_cmp++; if (bus.HSYNC !== 1'b0 || bus.VSYNC !== 1'b1) begin n_err++; $display("FAIL sync_swap got hs=%b vs=%b want hs=0 vs=1", bus.HSYNC, bus.VSYNC); end
    bus.VSYNC_IN = 1'b0; bus.CE = 1'b0;
    cyc();
    n_cmp++; if (bus.VSYNC !== 1'b1) begin n_err++; $display("FAIL vs_noce got %b want 1", bus.VSYNC); end
    bus.CE = 1'b1;
    cyc();
    n_cmp++; if (bus.VSYNC !== 1'b0) begin n_err++; $display("FAIL vs_ce got %b want 0", bus.VSYNC); end
    bus.CE = 1'b0;
  endtask

  // Both paddles parked at the top: every rally ends with the ball passing the
  // right paddle, and the left paddle returns every serve heading left.
  task automatic test_game();
    logic [11:0] c;
    do_reset();
    bus.BTN_UP_L = 1'b1; bus.BTN_UP_R = 1'b1;
    tick_n(218);
    n_cmp++; if (bus.SCORE_L !== 4'd0) begin n_err++; $display("FAIL pre_point1 got %0d want 0", bus.SCORE_L); end
    probe(632, 394, 1'b1, c); n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL ball_at_edge got %h want FFF", c); end
    tick_n(1);
    n_cmp++; if (bus.SCORE_L !== 4'd1 || bus.SCORE_R !== 4'd0) begin n_err++; $display("FAIL point1 got %0d/%0d want 1/0", bus.SCORE_L, bus.SCORE_R); end
    probe(316, 236, 1'b1, c); n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL recentre got %h want FFF", c); end
    tick_n(60);
    probe(316, 236, 1'b1, c); n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL reserve_end got %h want FFF", c); end
    tick_n(1);
    probe(314, 234, 1'b1, c); n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL vx_neg got %h want FFF", c); end
    probe(313, 234, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL vx_neg_left got %h want 000", c); end
    tick_n(117);
    probe(80, 0, 1'b1, c);    n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL top_wall got %h want FFF", c); end
    tick_n(2);
    probe(76, 2, 1'b1, c);    n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL vy_flip got %h want FFF", c); end
    probe(76, 1, 1'b1, c);    n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL vy_flip_above got %h want 000", c); end
    tick_n(18);
    probe(40, 38, 1'b1, c);   n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL hit_clamp got %h want FFF", c); end
    probe(39, 38, 1'b1, c);   n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL hit_paddle got %h want 0F0", c); end
    tick_n(1);
    probe(42, 40, 1'b1, c);   n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL hit_vx_pos got %h want FFF", c); end
    probe(41, 40, 1'b1, c);   n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL hit_vx_pos_left got %h want 000", c); end
    tick_n(295);
    n_cmp++; if (bus.SCORE_L !== 4'd1) begin n_err++; $display("FAIL pre_point2 got %0d want 1", bus.SCORE_L); end
    tick_n(1);
    n_cmp++; if (bus.SCORE_L !== 4'd2) begin n_err++; $display("FAIL point2 got %0d want 2", bus.SCORE_L); end
    tick_n(3464);
    n_cmp++; if (bus.SCORE_L !== 4'd8 || bus.GAME_OVER !== 1'b0) begin n_err++; $display("FAIL pre_win got %0d go=%b want 8 go=0", bus.SCORE_L, bus.GAME_OVER); end
    tick_n(1);
    n_cmp++; if (bus.SCORE_L !== 4'd9 || bus.GAME_OVER !== 1'b1) begin n_err++; $display("FAIL win got %0d go=%b want 9 go=1", bus.SCORE_L, bus.GAME_OVER); end
    n_cmp++; if (bus.SCORE_R !== 4'd0) begin n_err++; $display("FAIL win_score_r got %0d want 0", bus.SCORE_R); end
    probe(316, 236, 1'b1, c); n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL over_no_ball got %h want 000", c); end
    bus.BTN_UP_L = 1'b0; bus.BTN_DN_L = 1'b1;
    tick_n(5);
    probe(32, 0, 1'b1, c);    n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL over_frozen_top got %h want 0F0", c); end
    probe(32, 80, 1'b1, c);   n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL over_frozen_below got %h want 000", c); end
    n_cmp++; if (bus.SCORE_L !== 4'd9 || bus.GAME_OVER !== 1'b1) begin n_err++; $display("FAIL over_hold got %0d go=%b want 9 go=1", bus.SCORE_L, bus.GAME_OVER); end
    bus.BTN_DN_L = 1'b0; bus.BTN_UP_R = 1'b0;
    do_reset();
    n_cmp++; if (bus.SCORE_L !== 4'd0 || bus.GAME_OVER !== 1'b0 || bus.RGB !== 12'h000) begin n_err++; $display("FAIL post_rst got %0d go=%b rgb=%h want 0 go=0 rgb=000", bus.SCORE_L, bus.GAME_OVER, bus.RGB); end
    probe(32, 200, 1'b1, c);  n_cmp++; if (c !== 12'h0F0) begin n_err++; $display("FAIL post_rst_pad got %h want 0F0", c); end
    probe(32, 199, 1'b1, c);  n_cmp++; if (c !== 12'h000) begin n_err++; $display("FAIL post_rst_pad_above got %h want 000", c); end
    probe(316, 236, 1'b1, c); n_cmp++; if (c !== 12'hFFF) begin n_err++; $display("FAIL post_rst_ball got %h want FFF", c); end
  endtask

  initial begin
    RESET = 1'b1;
    bus.CE = 1'b0; bus.VIDEO_ON = 1'b0; bus.HSYNC_IN = 1'b0; bus.VSYNC_IN = 1'b0;
    bus.X = 10'd0; bus.Y = 10'd0;
    bus.BTN_UP_L = 1'b0; bus.BTN_DN_L = 1'b0; bus.BTN_UP_R = 1'b0; bus.BTN_DN_R = 1'b0;
    test_reset();
    test_mid_reset();
    test_paddle();
    test_serve_motion();
    test_game();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
